// File: rtl/alu_frame_ctrl_pkg.sv
// Shared definitions for the ALU frame controller: ALU opcodes, framing defaults
// and the controller state encoding.
package alu_pkg;

  typedef enum logic [2:0] {
    CS_AND  = 3'd0,
    CS_OR   = 3'd1,
    CS_ADD  = 3'd2,
    CS_SUB  = 3'd3,
    CS_SLT  = 3'd4,
    CS_SUBC = 3'd5,
    CS_ADDC = 3'd6
  } alu_cs_e;

  localparam logic [3:0]  SYNC_NIBBLE_DEFAULT    = 4'hA;
  localparam logic [15:0] TIMEOUT_CYCLES_DEFAULT = 16'd5000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_EXEC,
    ST_WAIT1,
    ST_CAPTURE,
    ST_SEND_RES,
    ST_SEND_STAT
  } frame_state_e;

  // The optional second reply byte: carry in bit 1, zero flag in bit 0.
  function automatic logic [7:0] status_byte(input logic carry, input logic zero);
    return {6'b000000, carry, zero};
  endfunction

endpackage

// File: rtl/alu_frame_ctrl_if.sv
// Byte-stream link between the UART (master) and the ALU frame controller (slave):
// one valid/ready channel in each direction.
interface alu_frame_ctrl_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/alu_frame_ctrl.sv
// Turns 3-byte UART frames (opcode, A, B) into one ALU operation and sends the result back.
// Define ALU_STATUS_BYTE_EN to also send a {carry, zero} status byte after the result.
module alu_frame_ctrl
  import alu_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [3:0]  SYNC_NIBBLE    = SYNC_NIBBLE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_frame_ctrl_if.slave  bus,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_cs,
  output logic             alu_carry_in,
  output logic             alu_en,
  input  logic [7:0]       alu_s,
  input  logic             alu_zero,
  input  logic             alu_carry_out,
  output logic             busy,
  output logic             frame_err
);

  frame_state_e state, state_next;

  logic [15:0] idle_cnt;
  logic [7:0]  result_q;
  logic        carry_q;
  logic        zero_q;

  logic        rx_ready_c;
  logic        tx_valid_c;
  logic [7:0]  tx_data_c;
  logic        rx_accept;
  logic        in_get;
  logic        sync_ok;
  logic        bad_sync;
  logic        timeout;

  // rx_ready is gated by reset because the state register reads IDLE while reset is held.
  assign in_get     = (state == ST_GET_A) || (state == ST_GET_B);
  assign rx_ready_c = !rst_n && ((state == ST_IDLE) || in_get);
  assign rx_accept  = rx_ready_c && bus.rx_valid;
  assign sync_ok    = (bus.rx_data[7:4] == SYNC_NIBBLE);
  assign bad_sync   = (state == ST_IDLE) && rx_accept && !sync_ok;
  assign timeout    = in_get && !rx_accept &&
                      (({1'b0, idle_cnt} + 17'd1) >= {1'b0, TIMEOUT_CYCLES});

  assign bus.rx_ready = rx_ready_c;
  assign bus.tx_valid = tx_valid_c;
  assign bus.tx_data  = tx_data_c;
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tx_valid_c = 1'b0;
    tx_data_c  = 8'h00;
    alu_en     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rx_accept && sync_ok) state_next = ST_GET_A;
      end
      ST_GET_A: begin
        if (rx_accept)    state_next = ST_GET_B;
        else if (timeout) state_next = ST_IDLE;
      end
      ST_GET_B: begin
        if (rx_accept)    state_next = ST_EXEC;
        else if (timeout) state_next = ST_IDLE;
      end
      ST_EXEC: begin
        alu_en     = 1'b1;
        state_next = ST_WAIT1;
      end
      ST_WAIT1: begin
        state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_next = ST_SEND_RES;
      end
      ST_SEND_RES: begin
        tx_valid_c = 1'b1;
        tx_data_c  = result_q;
        if (bus.tx_ready) begin
`ifdef ALU_STATUS_BYTE_EN
          state_next = ST_SEND_STAT;
`else
          state_next = ST_IDLE;
`endif
        end
      end
      ST_SEND_STAT: begin
        tx_valid_c = 1'b1;
        tx_data_c  = status_byte(carry_q, zero_q);
        if (bus.tx_ready) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operands and opcode hold their values across timeouts and errors until a new
  // opcode is accepted; the ALU result is sampled two cycles after the enable pulse.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      alu_a        <= 8'h00;
      alu_b        <= 8'h00;
      alu_cs       <= 3'd0;
      alu_carry_in <= 1'b0;
      result_q     <= 8'h00;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && rx_accept && sync_ok) begin
        alu_cs       <= bus.rx_data[2:0];
        alu_carry_in <= bus.rx_data[3];
      end
      if ((state == ST_GET_A) && rx_accept) alu_a <= bus.rx_data;
      if ((state == ST_GET_B) && rx_accept) alu_b <= bus.rx_data;
      if (state == ST_CAPTURE) begin
        result_q <= alu_s;
        carry_q  <= alu_carry_out;
        zero_q   <= alu_zero;
      end
    end
  end

  // The idle counter only runs while waiting for operand bytes and is cleared by
  // every accepted byte, by a timeout and by leaving the operand states.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      idle_cnt  <= 16'd0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad_sync || timeout;
      if (in_get && !rx_accept && !timeout) begin
        if (idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;
      end else begin
        idle_cnt <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Self-checking bench for alu_frame_ctrl: vector table, randomized frames against a
// behavioural ALU model, and hand-written error, timeout, back-pressure and reset cases.
module tb_alu_frame_ctrl;
  import alu_pkg::*;

  localparam logic [15:0] TIMEOUT = 16'd20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_cs;
  logic       alu_carry_in, alu_en, busy, frame_err;
  logic [7:0] alu_s = 8'h00;
  logic       alu_zero = 1'b0;
  logic       alu_carry_out = 1'b0;

  int checks = 0;
  int errors = 0;
  int en_total = 0;
  int err_total = 0;

  always #5 clk = ~clk;

  alu_frame_ctrl_if bus();

  alu_frame_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_NIBBLE(4'hA)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_cs        (alu_cs),
    .alu_carry_in  (alu_carry_in),
    .alu_en        (alu_en),
    .alu_s         (alu_s),
    .alu_zero      (alu_zero),
    .alu_carry_out (alu_carry_out),
    .busy          (busy),
    .frame_err     (frame_err)
  );

  // Behavioural ALU: returns {carry, zero, result} using plain integer arithmetic.
  function automatic logic [9:0] alu_ref(input logic [2:0] cs, input logic cin,
                                         input logic [7:0] a, input logic [7:0] b);
    int r, ia, ib, ic;
    logic c;
    logic [7:0] s;
    ia = int'(a); ib = int'(b); ic = int'(cin); c = 1'b0; r = 0;
    case (cs)
      3'd0: r = ia & ib;
      3'd1: r = ia | ib;
      3'd2: begin r = ia + ib;      c = (r > 255); end
      3'd3: begin r = ia - ib;      c = (r < 0);   end
      3'd4: r = ($signed(a) < $signed(b)) ? 1 : 0;
      3'd5: begin r = ia - ib - ic; c = (r < 0);   end
      3'd6: begin r = ia + ib + ic; c = (r > 255); end
      default: r = 0;
    endcase
    s = r[7:0];
    return {c, (s == 8'h00), s};
  endfunction

  // Registered ALU stub: results appear the cycle after the enable pulse.
  always @(posedge clk) begin
    if (alu_en) {alu_carry_out, alu_zero, alu_s} <= alu_ref(alu_cs, alu_carry_in, alu_a, alu_b);
  end

  always @(posedge clk) begin
    if (alu_en)    en_total  <= en_total + 1;
    if (frame_err) err_total <= err_total + 1;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_expired(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_rx_ready"},  bus.rx_ready, 0);
    check_output({tag, "_tx_valid"},  bus.tx_valid, 0);
    check_output({tag, "_tx_data"},   bus.tx_data, 0);
    check_output({tag, "_alu_a"},     alu_a, 0);
    check_output({tag, "_alu_b"},     alu_b, 0);
    check_output({tag, "_alu_cs"},    alu_cs, 0);
    check_output({tag, "_carry_in"},  alu_carry_in, 0);
    check_output({tag, "_alu_en"},    alu_en, 0);
    check_output({tag, "_busy"},      busy, 0);
    check_output({tag, "_frame_err"}, frame_err, 0);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output({tag, "_post_rx_ready"}, bus.rx_ready, 1);
    check_output({tag, "_post_busy"},     busy, 0);
  endtask

  // Offers one byte and returns at the negedge after the edge that accepted it.
  task automatic apply_stimulus(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) wait_expired("rx_ready_wait");
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Waits for an offered byte, holds tx_ready low for 'stall' cycles while checking
  // that the offer is stable, then takes it.
  task automatic receive_byte(input int stall, output logic [7:0] b);
    int n;
    logic [7:0] first;
    n = 0;
    b = 8'h00;
    bus.tx_ready = 1'b0;
    while (bus.tx_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      wait_expired("tx_valid_wait");
      return;
    end
    first = bus.tx_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_output("stall_tx_valid", bus.tx_valid, 1);
      check_output("stall_tx_data",  bus.tx_data, first);
      check_output("stall_rx_ready", bus.rx_ready, 0);
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    b = first;
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int stall, input logic [7:0] exp_res,
                           input logic [7:0] exp_stat, input string tag);
    int en0;
    logic [7:0] got;
    en0 = en_total;
    apply_stimulus(op);
    apply_stimulus(a);
    apply_stimulus(b);
    receive_byte(stall, got);
    check_output({tag, "_result"}, got, exp_res);
`ifdef ALU_STATUS_BYTE_EN
    receive_byte(stall, got);
    check_output({tag, "_status"}, got, exp_stat);
`else
    if (stall > 10) $display("[TB] %s: status 0x%0h not sent in this build", tag, exp_stat);
`endif
    check_output({tag, "_tx_valid_after"}, bus.tx_valid, 0);
    check_output({tag, "_busy_after"},     busy, 0);
    check_output({tag, "_rx_ready_after"}, bus.rx_ready, 1);
    check_output({tag, "_alu_en_pulses"},  en_total - en0, 1);
    check_output({tag, "_alu_cs"},         alu_cs, op[2:0]);
    check_output({tag, "_carry_in"},       alu_carry_in, op[3]);
    check_output({tag, "_alu_a"},          alu_a, a);
    check_output({tag, "_alu_b"},          alu_b, b);
  endtask

  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_res;
    logic [7:0] exp_stat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int en0, err0, first_err, busy_early, saw_tx;
    logic [2:0] cs;
    logic cin;
    logic [7:0] a, b, op, bad;
    logic [3:0] nib;
    logic [9:0] r;

    vecs[0] = '{8'hA2, 8'h05, 8'h03, 8'h08, 8'h00};
    vecs[1] = '{8'hA6, 8'hFF, 8'h01, 8'h00, 8'h03};
    vecs[2] = '{8'hA0, 8'hF0, 8'h3C, 8'h30, 8'h00};
    vecs[3] = '{8'hA1, 8'h0F, 8'hF0, 8'hFF, 8'h00};
    vecs[4] = '{8'hA3, 8'h03, 8'h05, 8'hFE, 8'h02};
    vecs[5] = '{8'hA4, 8'h80, 8'h01, 8'h01, 8'h00};
    vecs[6] = '{8'hA4, 8'h01, 8'h80, 8'h00, 8'h01};
    vecs[7] = '{8'hAD, 8'h10, 8'h05, 8'h0A, 8'h00};
    vecs[8] = '{8'hAE, 8'h7F, 8'h80, 8'h00, 8'h03};
    vecs[9] = '{8'hA0, 8'hAA, 8'h55, 8'h00, 8'h01};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    release_reset("reset");

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i].op, vecs[i].a, vecs[i].b, i % 3, vecs[i].exp_res, vecs[i].exp_stat,
                $sformatf("vec%0d", i));
    end

    // Bad sync nibble: one error pulse, no ALU activity, then a normal frame.
    en0  = en_total;
    err0 = err_total;
    apply_stimulus(8'h52);
    check_output("badsync_frame_err", frame_err, 1);
    check_output("badsync_busy",      busy, 0);
    @(negedge clk);
    check_output("badsync_pulse_end", frame_err, 0);
    check_output("badsync_err_count", err_total - err0, 1);
    check_output("badsync_no_alu_en", en_total - en0, 0);
    run_frame(8'hA2, 8'h05, 8'h03, 0, 8'h08, 8'h00, "after_badsync");

    // Timeout in GET_B after TIMEOUT idle cycles.
    en0 = en_total;
    err0 = err_total;
    apply_stimulus(8'hA0);
    apply_stimulus(8'h0F);
    first_err = 0;
    busy_early = 0;
    saw_tx = 0;
    for (int k = 1; k <= int'(TIMEOUT) + 3; k++) begin
      @(negedge clk);
      if (bus.tx_valid) saw_tx = 1;
      if (frame_err && first_err == 0) first_err = k;
      if (k < int'(TIMEOUT) && !busy) busy_early = 1;
    end
    check_output("timeout_in_window", (first_err >= int'(TIMEOUT)) && (first_err <= int'(TIMEOUT) + 1), 1);
    check_output("timeout_busy_before", busy_early, 0);
    check_output("timeout_err_count", err_total - err0, 1);
    check_output("timeout_idle", busy, 0);
    check_output("timeout_no_tx", saw_tx, 0);
    check_output("timeout_no_alu_en", en_total - en0, 0);

    // Long TX back-pressure.
    run_frame(8'hA2, 8'h05, 8'h03, 20, 8'h08, 8'h00, "stall20");

    // Reset while waiting for operand B.
    apply_stimulus(8'hA2);
    apply_stimulus(8'h05);
    check_output("midframe_busy", busy, 1);
    rst_n = 1'b1;
    #1;
    check_reset_values("midreset");
    repeat (2) @(negedge clk);
    release_reset("midreset");
    run_frame(8'hA2, 8'h05, 8'h03, 1, 8'h08, 8'h00, "after_reset");

    // Randomized frames, some preceded by a byte with a wrong sync nibble.
    for (int i = 0; i < 30; i++) begin
      cs  = 3'($urandom_range(0, 6));
      cin = 1'($urandom_range(0, 1));
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      op  = {4'hA, cin, cs};
      if ($urandom_range(0, 3) == 0) begin
        nib = 4'($urandom_range(0, 14));
        if (nib >= 4'hA) nib = nib + 4'd1;
        bad = {nib, 4'($urandom_range(0, 15))};
        err0 = err_total;
        apply_stimulus(bad);
        @(negedge clk);
        check_output("rand_badsync_err", err_total - err0, 1);
      end
      r = alu_ref(cs, cin, a, b);
      run_frame(op, a, b, $urandom_range(0, 3), r[7:0], status_byte(r[9], r[8]),
                $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_frame_ctrl.md
ALU_FRAME_CTRL -- requirements
Module: alu_frame_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd5000, maximum idle clk cycles between bytes of one frame.
REQ-002 SHALL have parameter SYNC_NIBBLE, default 4'hA, required value of opcode byte bits[7:4].
REQ-003 SHALL use reset rst_n, asynchronous, active-high; clock clk.
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1 async active-high reset.
REQ-005 SHALL have ports: rx_data in 8 UART RX byte; rx_valid in 1 byte present; rx_ready out 1 byte accepted.
REQ-006 SHALL have ports: tx_data out 8 byte to UART TX; tx_valid out 1 byte offered; tx_ready in 1 TX can accept.
REQ-007 SHALL have ports: alu_a out 8; alu_b out 8; alu_cs out 3; alu_carry_in out 1; alu_en out 1 (ALU operands/opcode/carry/enable).
REQ-008 SHALL have ports: alu_s in 8; alu_zero in 1; alu_carry_out in 1 (registered ALU results).
REQ-009 SHALL have ports: busy out 1 frame in progress; frame_err out 1 one-cycle error pulse.

Function
REQ-010 SHALL run FSM IDLE -> GET_A -> GET_B -> EXEC -> WAIT1 -> CAPTURE -> SEND_RES [-> SEND_STAT] -> IDLE.
REQ-011 RX byte transfer SHALL occur when rx_valid && rx_ready at a clk edge; rx_ready=1 only in IDLE, GET_A, GET_B.
REQ-012 In IDLE, accepted byte with bits[7:4]==SYNC_NIBBLE SHALL latch alu_cs=bits[2:0], alu_carry_in=bit[3], go GET_A; otherwise byte discarded, frame_err pulses, stay IDLE.
REQ-013 GET_A SHALL latch accepted byte into alu_a; GET_B into alu_b, then go EXEC.
REQ-014 EXEC SHALL drive alu_en=1 for exactly one cycle; alu_en=0 in all other states.
REQ-015 CAPTURE (second cycle after EXEC) SHALL latch alu_s, alu_zero, alu_carry_out into internal registers; result byte = captured alu_s.
REQ-016 SEND_RES SHALL hold tx_valid=1, tx_data=result until tx_ready=1 at an edge, then advance; tx_data SHALL not change while tx_valid=1.
REQ-017 Operand/opcode outputs SHALL remain stable from latch until next frame opcode accepted.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 Timeout counter SHALL reset on every accepted byte and count in GET_A/GET_B; reaching TIMEOUT_CYCLES SHALL pulse frame_err and return to IDLE, discarding partial frame.
REQ-020 Timeout SHALL not apply in EXEC..SEND_*; TX back-pressure may stall indefinitely.
REQ-021 Counter SHALL saturate, never wrap.

Reset
REQ-022 While rst_n=1, SHALL force IDLE; rx_ready=0, tx_valid=0, tx_data=0, alu_a=0, alu_b=0, alu_cs=0, alu_carry_in=0, alu_en=0, busy=0, frame_err=0, counter=0.
REQ-023 Reset mid-frame or mid-transmit SHALL abandon the frame; first cycle after release SHALL be IDLE with rx_ready=1.

Configuration
REQ-024 With ALU_STATUS_BYTE_EN defined, SEND_RES SHALL go to SEND_STAT, sending {6'b0, carry, zero} under REQ-016 rules, then IDLE.
REQ-025 Without ALU_STATUS_BYTE_EN, SEND_RES SHALL go directly to IDLE; exactly one byte per frame.

Structure
REQ-026 Package alu_pkg SHALL hold cs encodings (AND=0, OR=1, ADD=2, SUB=3, SLT=4, SUBC=5, ADDC=6), SYNC_NIBBLE default, and FSM state typedef.
REQ-027 No sub-module: FSM, capture registers and timeout counter SHALL be in one module.

Verification
REQ-028 Bytes 0xA2, 0x05, 0x03, tx_ready=1 -> alu_en one pulse, cs=2, tx byte 0x08; with macro second byte 0x00.
REQ-029 Bytes 0xA6 (ADDC, carry_in=0), 0xFF, 0x01 with macro -> tx 0x00 then 0x03 (carry=1, zero=1).
REQ-030 Byte 0x52 in IDLE -> frame_err one-cycle pulse, no alu_en, stays IDLE; next valid frame processed normally.
REQ-031 0xA0, 0x0F then silence TIMEOUT_CYCLES -> frame_err pulse, IDLE, no alu_en, no tx_valid.
REQ-032 tx_ready=0 for 20 cycles during SEND_RES -> tx_valid and tx_data stable, rx_ready=0; transfer on first tx_ready=1.
REQ-033 rst_n asserted in GET_B -> all outputs at reset values; following full frame yields correct result.
